popcount_accum: RTL
===================

Name: popcount_accum

Overview:
Parametrised, streaming successor to the team's 4-input ones-counter. Accepts WIDTH-bit words over a valid/ready handshake. For each word it produces:
- the binary ones-count;
- a one-hot count vector, bit k set when exactly k input bits are 1, generalising the fixed 4-input one-hot outputs;
- a threshold flag.
It also keeps a running accumulator of ones seen, with overflow tracking. It sits between a data source and downstream statistics/control logic on the single system clock.

Parameters:
WIDTH, 8, input word width (>=1)
ACC_W, 16, accumulator width (>= CW)
SATURATE, 1, 1 = accumulator clamps at max; 0 = accumulator wraps
(derived) CW = $clog2(WIDTH+1), width of count

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-high reset (asserted = 1 despite the name)
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word this cycle
in_data  in  WIDTH  word to count
thresh  in  CW  threshold, sampled with the accepted word
clear  in  1  synchronous accumulator clear
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
count  out  CW  ones in the accepted word
onehot  out  WIDTH+1  onehot[k]=1 iff count==k
thr_hit  out  1  count >= sampled thresh
acc  out  ACC_W  running sum of counts
acc_ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - out_valid=0, count=0, onehot=0 (all zeros, not onehot[0]), thr_hit=0, acc=0, acc_ovf=0.
  - in_ready=0 while rst_n=1.
  - Reset overrides every other input, including mid-transfer; a pending result is discarded.
- Handshake:
  - in_ready = !rst_n_asserted && (!out_valid || out_ready), combinational.
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency and throughput:
  - Latency 1 cycle: the result for a word accepted at edge N is visible after edge N with out_valid=1.
  - Full throughput (1 word/cycle) while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, count/onehot/thr_hit/out_valid hold stable and no new word is accepted.
- Drain: after out_valid && out_ready with no accept on the same edge, out_valid goes to 0. Data outputs may hold their last value.
- Result arithmetic:
  - count = number of 1 bits in in_data, range 0..WIDTH.
  - onehot has exactly one bit set whenever out_valid=1.
  - thr_hit is an unsigned compare against thresh sampled at accept. thresh=0 gives thr_hit=1 always.
- Accumulator (updates only on accept, independent of the output handshake):
  - sum = acc + count, computed at ACC_W+1 bits.
  - SATURATE=1: if sum > 2^ACC_W-1, acc becomes 2^ACC_W-1 and acc_ovf is set. Further accepts keep acc at max.
  - SATURATE=0: acc becomes sum mod 2^ACC_W; acc_ovf is set on carry-out.
  - acc_ovf is sticky until clear or reset.
- Clear:
  - clear=1 without accept: acc=0, acc_ovf=0.
  - clear=1 with accept on the same edge: acc=count of that word, acc_ovf=0 (clear first, then add).
  - clear has no effect on out_valid/count/onehot/thr_hit.
- State: a two-state output register (EMPTY: out_valid=0; FULL: out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept (same-cycle transfer and refill) or while stalled.
  - FULL -> EMPTY on transfer without accept.

Test Plan:
1. Reset, then WIDTH=8: send in_data=0x00, thresh=1 -> next cycle out_valid=1, count=0, onehot=9'h001, thr_hit=0, acc=0.
2. Back-to-back words 0xFF, 0x0F, 0xA5 with out_ready=1, thresh=4 -> counts 8,4,4; onehot 9'h100, 9'h010, 9'h010; thr_hit 1,1,1; acc ends at 16; one result per cycle.
3. out_ready=0 for 3 cycles after accepting 0x03 -> in_ready=0, outputs hold count=2 for all stall cycles, acc=2, in_valid ignored. out_ready=1 then accepts the next word on that edge.
4. ACC_W=4, SATURATE=1: feed 0xFF twice -> acc=8, then 15, acc_ovf=1. Repeat with SATURATE=0 -> acc=8, then 0, acc_ovf=1.
5. clear asserted with acc=10 on the same edge as accepting 0x07 -> acc=3, acc_ovf=0, and the result count=3 is delivered normally.
6. Assert rst_n while out_valid=1 and stalled, acc nonzero -> next edge: all outputs 0, in_ready=0 during reset, in_ready=1 the cycle reset deasserts.

Source files
------------

// File: rtl/popcount_accum_if.sv
// ---------------------------------------------------------------------------
// popcount_accum_if
//
// Bundles the streaming input and result/accumulator signals of
// popcount_accum. Clock and reset stay plain ports on the block itself.
//
// Parameters:
//   WIDTH  input word width
//   ACC_W  accumulator width
//
// Signals:
//   in_valid  / in_ready   input handshake
//   in_data   [WIDTH]      word to count
//   thresh    [CW]         threshold, sampled with the accepted word
//   clear                  synchronous accumulator clear
//   out_valid / out_ready  result handshake
//   count     [CW]         ones in the accepted word
//   onehot    [WIDTH+1]    onehot[k] = 1 iff count == k
//   thr_hit                count >= sampled thresh
//   acc       [ACC_W]      running sum of counts
//   acc_ovf                sticky accumulator overflow
//
// Modports:
//   master  data source / result consumer side
//   slave   the popcount_accum block
// ---------------------------------------------------------------------------
interface popcount_accum_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CW-1:0]    thresh;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   onehot;
    logic             thr_hit;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;

    modport master (
        output in_valid, in_data, thresh, clear, out_ready,
        input  in_ready, out_valid, count, onehot, thr_hit, acc, acc_ovf
    );

    modport slave (
        input  in_valid, in_data, thresh, clear, out_ready,
        output in_ready, out_valid, count, onehot, thr_hit, acc, acc_ovf
    );
endinterface

// File: rtl/popcount_accum.sv
// ---------------------------------------------------------------------------
// popcount_accum
//
// Streaming ones-counter. Each accepted WIDTH-bit word produces, one cycle
// later, its binary ones-count, a one-hot encoding of that count and a
// threshold flag. A running accumulator sums the counts of all accepted
// words, either clamping at its maximum or wrapping, with a sticky
// overflow flag.
//
// Parameters:
//   WIDTH     input word width (>= 1)
//   ACC_W     accumulator width (>= $clog2(WIDTH+1))
//   SATURATE  1 = accumulator clamps at max, 0 = accumulator wraps
//
// Ports:
//   clk    system clock, everything on the rising edge
//   rst_n  synchronous reset, ACTIVE HIGH despite the name
//   bus    popcount_accum_if.slave (handshakes, data, accumulator)
//
// Handshake:
//   in_ready  = !reset && (!out_valid || out_ready)   (combinational)
//   accept    = in_valid && in_ready
//   transfer  = out_valid && out_ready
// The output register is a two-state machine: EMPTY (out_valid=0) and
// FULL (out_valid=1). A word accepted while FULL is only possible when the
// held result is leaving on the same edge, so full throughput is kept
// while out_ready stays high.
// ---------------------------------------------------------------------------
module popcount_accum #(
    parameter int WIDTH    = 8,
    parameter int ACC_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    popcount_accum_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    // Output register state.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   onehot_q, onehot_d;
    logic             thr_q, thr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             in_ready;
    logic             accept;
    logic             transfer;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum;

    // Ones-count of one word. A plain ripple of 1-bit adds; synthesis
    // rebalances it into a tree.
    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] w);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CW'(w[i]);
        end
        return n;
    endfunction

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // rst_n is active high: the block refuses input for as long as it is 1.
    assign in_ready = !rst_n && ((state_q == ST_EMPTY) || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign transfer = (state_q == ST_FULL) && bus.out_ready;

    // -----------------------------------------------------------------------
    // Result datapath: loads only on accept, otherwise holds (this gives
    // both the stall behaviour and "last value held" after a drain).
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        count_d  = count_q;
        onehot_d = onehot_q;
        thr_d    = thr_q;
        if (accept) begin
            count_d = popcount(bus.in_data);
            for (int k = 0; k <= WIDTH; k++) begin
                onehot_d[k] = (count_d == CW'(k));
            end
            // Unsigned compare; thresh == 0 always hits.
            thr_d = (count_d >= bus.thresh);
        end
    end

    // -----------------------------------------------------------------------
    // Output register FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            // An accept while FULL implies out_ready, i.e. the held result
            // leaves as the new one arrives: stay FULL.
            ST_FULL:  if (transfer && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // -----------------------------------------------------------------------
    // Accumulator: clear is applied first, then the accepted count added.
    // The sum is one bit wider so the carry-out is the overflow indication;
    // it can only be set on an accept since acc_base never exceeds max.
    // -----------------------------------------------------------------------
    always_comb begin
        acc_base = bus.clear ? '0 : acc_q;
        sum      = {1'b0, acc_base} + (accept ? (ACC_W + 1)'(count_d) : '0);
        if (sum[ACC_W]) begin
            acc_d = SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end else begin
            acc_d = sum[ACC_W-1:0];
        end
        // Sticky until clear/reset; a clear+accept that overflows again
        // still sets it.
        ovf_d = (bus.clear ? 1'b0 : ovf_q) | sum[ACC_W];
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the result registers are reset too, not just out_valid, because
    // the outputs must read as all zeros (onehot included) after reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= ST_EMPTY;
            count_q  <= '0;
            onehot_q <= '0;
            thr_q    <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            onehot_q <= onehot_d;
            thr_q    <= thr_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.count     = count_q;
    assign bus.onehot    = onehot_q;
    assign bus.thr_hit   = thr_q;
    assign bus.acc       = acc_q;
    assign bus.acc_ovf   = ovf_q;

endmodule
